disp_share_arbiter: RTL
=======================

Name: disp_share_arbiter

Overview:
Shares the four-digit 7-segment display between four independent pattern sources. Arbitration is round-robin with a minimum time slice per owner. The block drives the four digit pattern registers that feed disp_mux, in place of a single hard-wired pattern generator. A one-cycle blank guard separates every change of owner, so digits from two owners never mix.

Parameters:
- SLICE_W, default 24: slice counter width; the minimum ownership slice is 2^SLICE_W clock cycles (≈168 ms at 100 MHz).

Ports:
- clk  input  1  system clock (100 MHz)
- reset_n  input  1  synchronous, active-low reset
- req  input  4  request line per requester; level-sensitive, held while the requester wants the display
- pat_in  input  128  packed patterns: requester i uses pat_in[32*i +: 32]; digit k of requester i is bits [32*i+8*k +: 8]; active-low segments, bit 7 = dp
- gnt  output  4  one-hot grant, or all zero
- owner  output  2  index of the current/last granted requester
- busy  output  1  high while in GRANT
- d0, d1, d2, d3  output  8 each  digit patterns to disp_mux in0..in3

Behaviour:
- Single clock. Reset is synchronous and active-low, sampled on the clk rising edge.
- Reset values: state=IDLE, gnt=4'b0000, busy=0, owner=0, last_owner=3, slice_cnt=0, d0..d3=8'hFF (blank). After reset, req0 wins the first tie.
- All outputs are registered.
- Round-robin pick: search req starting at (last_owner+1) mod 4 and wrap; take the first set bit.
- IDLE:
  - gnt=0, digits=FF.
  - If any req bit is set: next state GRANT; owner=pick; gnt=onehot(pick); slice_cnt=0; d0..d3 load pat_in of pick on the same edge.
- GRANT:
  - busy=1.
  - Every edge, d0..d3 load owner's pat_in. Latency from pat_in to digit is 1 cycle.
  - slice_cnt increments and saturates at 2^SLICE_W-1.
  - Exit to SWITCH if req[owner]==0. An early release is honoured immediately, regardless of slice_cnt.
  - Exit to SWITCH if slice_cnt is saturated and any other req bit is set.
  - Otherwise stay in GRANT. A sole requester keeps the display indefinitely.
- SWITCH (exactly 1 cycle):
  - gnt=0, busy=0, digits=FF, last_owner<=owner.
  - Next state GRANT with a fresh pick if any req bit is set. The previous owner can be re-picked only if no other requester is active. Otherwise next state IDLE.
- Simultaneous release and slice expiry resolve as a release; the result is identical.
- A req that toggles while not owner has no effect until the next pick.
- Reset asserted during GRANT or SWITCH: the next edge gives the reset values; the owner is dropped with no SWITCH cycle.
- gnt is never multi-hot. gnt is never nonzero in IDLE or SWITCH.

Optional Feature:
Macro: DISP_ARB_PRIO0_EN.
- Defined: requester 0 is urgent. If req[0]=1 while another requester owns the display in GRANT, the next state is SWITCH regardless of slice_cnt. The following pick is forced to 0, ignoring round-robin. last_owner is still updated, so fairness among requesters 1–3 is preserved.
- Undefined: req[0] is an ordinary round-robin requester; no preemption logic is synthesised.

Test Plan:
All scenarios use SLICE_W=3 (slice = 8 cycles).
1. Reset then req=4'b0001, pat0=32'h9C9C9C9C -> gnt=0001 one cycle after req is seen; d0..d3=8'h9C; busy=1; owner=0.
2. Sole owner with pat0 changed to 32'hA3A3A3A3 mid-grant -> digits show A3 exactly 1 cycle later; gnt stays 0001 well beyond 8 cycles.
3. req=4'b1111 held -> grant order 0,1,2,3,0. Each grant lasts 8 cycles and is separated by one SWITCH cycle with gnt=0 and digits=FF.
4. Owner 2 drops req at cycle 3 of its slice while req3=1 -> SWITCH on the next cycle, then gnt=1000 with no wait for the slice.
5. reset_n=0 for one cycle during GRANT of owner 1 -> next cycle gnt=0, d=FF, state IDLE. With req=0010 still held, req1 is re-granted (last_owner=3).
6. DISP_ARB_PRIO0_EN defined: owner 3 at cycle 2 of its slice, req0 rises -> SWITCH next cycle, then gnt=0001. Undefined: owner 3 keeps the display for the full 8 cycles, then req0 is granted.

Source files
------------

// File: rtl/disp_share_arbiter.sv
// Round-robin sharing of the four-digit display between four pattern sources,
// with a minimum ownership slice and a one-cycle blank guard between owners.
// Optional macro DISP_ARB_PRIO0_EN makes requester 0 pre-empt any other owner.
module disp_share_arbiter #(
  parameter int SLICE_W = 24
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [3:0]   req,
  input  logic [127:0] pat_in,
  output logic [3:0]   gnt,
  output logic [1:0]   owner,
  output logic         busy,
  output logic [7:0]   d0,
  output logic [7:0]   d1,
  output logic [7:0]   d2,
  output logic [7:0]   d3
);

  // Handshake: req is a level held by a source for as long as it wants the
  // display; gnt is a registered one-hot answer, never asserted in IDLE/SWITCH.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_SWITCH = 2'd2
  } state_t;

  localparam logic [SLICE_W-1:0] CNT_MAX = {SLICE_W{1'b1}};

  state_t             state_q, state_d;
  logic [3:0]         gnt_q, gnt_d;
  logic [1:0]         owner_q, owner_d;
  logic [1:0]         last_owner_q, last_owner_d;
  logic [SLICE_W-1:0] slice_cnt_q, slice_cnt_d;
  logic [31:0]        digits_q, digits_d;
  logic               busy_q, busy_d;

  logic [31:0] pat_arr [4];
  logic [1:0]  pick;
  logic [1:0]  sw_pick;
  logic        release_w;
  logic        expire_w;
  logic        exit_w;

`ifdef DISP_ARB_PRIO0_EN
  logic prio_pend_q, prio_pend_d;
  logic preempt_w;
`endif

  // First set bit searching upward from last+1; last itself has lowest rank.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = last;
    for (int i = 4; i >= 1; i--) begin
      idx = last + 2'(i);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  always_comb begin
    for (int i = 0; i < 4; i++) pat_arr[i] = pat_in[32*i +: 32];
  end

  always_comb begin
    pick      = rr_pick(req, last_owner_q);
    release_w = !req[owner_q];
    expire_w  = (slice_cnt_q == CNT_MAX) && (|(req & ~(4'b0001 << owner_q)));
`ifdef DISP_ARB_PRIO0_EN
    preempt_w = (owner_q != 2'd0) && req[0];
    exit_w    = release_w || expire_w || preempt_w;
    sw_pick   = (prio_pend_q && req[0]) ? 2'd0 : pick;
`else
    exit_w    = release_w || expire_w;
    sw_pick   = pick;
`endif
  end

  always_comb begin
    state_d      = state_q;
    gnt_d        = 4'b0000;
    busy_d       = 1'b0;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    slice_cnt_d  = slice_cnt_q;
    digits_d     = 32'hFFFF_FFFF;
`ifdef DISP_ARB_PRIO0_EN
    prio_pend_d  = prio_pend_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d     = ST_GRANT;
          owner_d     = pick;
          gnt_d       = 4'b0001 << pick;
          busy_d      = 1'b1;
          slice_cnt_d = '0;
          digits_d    = pat_arr[pick];
        end
      end
      ST_GRANT: begin
        if (exit_w) begin
          state_d      = ST_SWITCH;
          last_owner_d = owner_q;
`ifdef DISP_ARB_PRIO0_EN
          prio_pend_d  = preempt_w;
`endif
        end else begin
          gnt_d       = gnt_q;
          busy_d      = 1'b1;
          digits_d    = pat_arr[owner_q];
          slice_cnt_d = (slice_cnt_q == CNT_MAX) ? slice_cnt_q : slice_cnt_q + SLICE_W'(1);
        end
      end
      ST_SWITCH: begin
`ifdef DISP_ARB_PRIO0_EN
        prio_pend_d = 1'b0;
`endif
        if (|req) begin
          state_d     = ST_GRANT;
          owner_d     = sw_pick;
          gnt_d       = 4'b0001 << sw_pick;
          busy_d      = 1'b1;
          slice_cnt_d = '0;
          digits_d    = pat_arr[sw_pick];
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      gnt_q        <= 4'b0000;
      busy_q       <= 1'b0;
      owner_q      <= 2'd0;
      last_owner_q <= 2'd3;
      slice_cnt_q  <= '0;
      digits_q     <= 32'hFFFF_FFFF;
`ifdef DISP_ARB_PRIO0_EN
      prio_pend_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      busy_q       <= busy_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      slice_cnt_q  <= slice_cnt_d;
      digits_q     <= digits_d;
`ifdef DISP_ARB_PRIO0_EN
      prio_pend_q  <= prio_pend_d;
`endif
    end
  end

  assign gnt   = gnt_q;
  assign busy  = busy_q;
  assign owner = owner_q;
  assign d0    = digits_q[7:0];
  assign d1    = digits_q[15:8];
  assign d2    = digits_q[23:16];
  assign d3    = digits_q[31:24];

endmodule
